dcache_dm: RTL and testbench

DCACHE_DM -- requirements
Module: dcache_dm

---
 rtl/dcache_dm_if.sv | 31 +++
 rtl/dcache_dm.sv | 120 ++++++++++++
 tb/tb_dcache_dm.sv | 294 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/dcache_dm_if.sv
// CPU-side and physical-memory-side signals of the direct-mapped data cache.
// The master modport is the environment (CPU + memory); the slave modport is the cache.
interface dcache_dm_if;
  logic [15:0]  mem_address;
  logic         mem_read;
  logic         mem_write;
  logic [1:0]   mem_byte_enable;
  logic [15:0]  mem_wdata;
  logic [15:0]  mem_rdata;
  logic         mem_resp;
  logic [15:0]  pmem_address;
  logic         pmem_read;
  logic         pmem_write;
  logic [127:0] pmem_wdata;
  logic [127:0] pmem_rdata;
  logic         pmem_resp;

  modport master (
    output mem_address, mem_read, mem_write, mem_byte_enable, mem_wdata,
    input  mem_rdata, mem_resp,
    input  pmem_address, pmem_read, pmem_write, pmem_wdata,
    output pmem_rdata, pmem_resp
  );

  modport slave (
    input  mem_address, mem_read, mem_write, mem_byte_enable, mem_wdata,
    output mem_rdata, mem_resp,
    output pmem_address, pmem_read, pmem_write, pmem_wdata,
    input  pmem_rdata, pmem_resp
  );
endinterface

// File: rtl/dcache_dm.sv
// Direct-mapped, write-back, write-allocate data cache with 16-byte lines.
// Hits complete combinationally in IDLE; misses go through WRITEBACK (if dirty) and FILL.
module dcache_dm #(
  parameter int unsigned SETS = 8
) (
  input  logic        clk,
  input  logic        reset,
  dcache_dm_if.slave  bus
);
  localparam int unsigned IW = $clog2(SETS);
  localparam int unsigned TW = 12 - IW;

  typedef enum logic [1:0] {IDLE, WRITEBACK, FILL} state_e;

  state_e          state_q, state_d;
  logic [SETS-1:0] valid_q, valid_d;
  logic [SETS-1:0] dirty_q, dirty_d;
  logic [IW-1:0]   miss_idx_q, miss_idx_d;
  logic [TW-1:0]   miss_tag_q, miss_tag_d;
  logic [TW-1:0]   tag_q  [SETS];
  logic [127:0]    data_q [SETS];

  logic [IW-1:0]   idx;
  logic [TW-1:0]   tag;
  logic [2:0]      word;
  logic            req, hit, wr_hit, fill;
  logic [127:0]    line, merged;
  logic            unused_addr_bit;

  assign idx             = bus.mem_address[4+IW-1:4];
  assign tag             = bus.mem_address[15:4+IW];
  assign word            = bus.mem_address[3:1];
  assign unused_addr_bit = bus.mem_address[0];
  assign req             = bus.mem_read | bus.mem_write;
  assign hit             = req && valid_q[idx] && (tag_q[idx] == tag);
  assign line            = data_q[idx];

  always_comb begin
    state_d              = state_q;
    valid_d              = valid_q;
    dirty_d              = dirty_q;
    miss_idx_d           = miss_idx_q;
    miss_tag_d           = miss_tag_q;
    wr_hit               = 1'b0;
    fill                 = 1'b0;
    bus.mem_resp         = 1'b0;
    bus.mem_rdata        = '0;
    bus.pmem_read        = 1'b0;
    bus.pmem_write       = 1'b0;
    bus.pmem_address     = '0;
    bus.pmem_wdata       = '0;
    merged               = line;
    for (int unsigned b = 0; b < 2; b++) begin
      if (bus.mem_byte_enable[b])
        merged[16*word + 8*b +: 8] = bus.mem_wdata[8*b +: 8];
    end

    unique case (state_q)
      IDLE: begin
        if (hit) begin
          bus.mem_resp = 1'b1;
          // A simultaneous read+write is a write, so it returns no read data.
          if (bus.mem_write) begin
            wr_hit = |bus.mem_byte_enable;
            if (|bus.mem_byte_enable) dirty_d[idx] = 1'b1;
          end else begin
            bus.mem_rdata = line[16*word +: 16];
          end
        end else if (req) begin
          miss_idx_d = idx;
          miss_tag_d = tag;
          state_d    = (valid_q[idx] && dirty_q[idx]) ? WRITEBACK : FILL;
        end
      end
      WRITEBACK: begin
        bus.pmem_write   = 1'b1;
        bus.pmem_address = {tag_q[miss_idx_q], miss_idx_q, 4'b0};
        bus.pmem_wdata   = data_q[miss_idx_q];
        if (bus.pmem_resp) state_d = FILL;
      end
      FILL: begin
        bus.pmem_read    = 1'b1;
        bus.pmem_address = {miss_tag_q, miss_idx_q, 4'b0};
        if (bus.pmem_resp) begin
          fill                = 1'b1;
          valid_d[miss_idx_q] = 1'b1;
          dirty_d[miss_idx_q] = 1'b0;
          state_d             = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      valid_q    <= '0;
      dirty_q    <= '0;
      miss_idx_q <= '0;
      miss_tag_q <= '0;
    end else begin
      state_q    <= state_d;
      valid_q    <= valid_d;
      dirty_q    <= dirty_d;
      miss_idx_q <= miss_idx_d;
      miss_tag_q <= miss_tag_d;
    end
  end

  // Tag and data arrays carry no reset; the valid bits gate every use of them.
  always_ff @(posedge clk) begin
    if (fill) begin
      data_q[miss_idx_q] <= bus.pmem_rdata;
      tag_q[miss_idx_q]  <= miss_tag_q;
    end else if (wr_hit) begin
      data_q[idx] <= merged;
    end
  end
endmodule

// File: tb/tb_dcache_dm.sv
// Self-checking bench for dcache_dm: vector table through a CPU scoreboard,
// a latency-LAT memory responder, and hand sequences for abandoned misses and reset aborts.
module tb_dcache_dm;
  localparam int LAT = 3;
  localparam int NV  = 16;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  dcache_dm_if bus ();
  dcache_dm #(.SETS(8)) dut (.clk(clk), .reset(reset), .bus(bus));

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Physical memory model
  logic [127:0] mem [logic [15:0]];
  logic [15:0]  wb_addr_q[$];
  logic [127:0] wb_data_q[$];
  logic [15:0]  fill_addr_q[$];
  bit           mem_hold = 1'b0;
  int           cnt;

  function automatic logic [127:0] pattern(input logic [15:0] a);
    logic [127:0] p;
    for (int w = 0; w < 8; w++) p[16*w +: 16] = a + 16'(2*w);
    return p;
  endfunction

  function automatic logic [127:0] mem_get(input logic [15:0] a);
    if (mem.exists(a)) return mem[a];
    return pattern(a);
  endfunction

  initial begin
    bus.pmem_resp  = 1'b0;
    bus.pmem_rdata = '0;
    cnt = 0;
    forever begin
      @(posedge clk);
      #1;
      if (!mem_hold) begin
        bus.pmem_resp = 1'b0;
        if (reset !== 1'b1) cnt = 0;
        else if (bus.pmem_write === 1'b1) begin
          cnt++;
          if (cnt == LAT) begin
            cnt = 0;
            mem[bus.pmem_address] = bus.pmem_wdata;
            wb_addr_q.push_back(bus.pmem_address);
            wb_data_q.push_back(bus.pmem_wdata);
            bus.pmem_resp = 1'b1;
          end
        end else if (bus.pmem_read === 1'b1) begin
          cnt++;
          if (cnt == LAT) begin
            cnt = 0;
            bus.pmem_rdata = mem_get(bus.pmem_address);
            fill_addr_q.push_back(bus.pmem_address);
            bus.pmem_resp = 1'b1;
          end
        end else cnt = 0;
      end
    end
  end

  // Per-cycle protocol properties
  initial begin
    forever begin
      @(negedge clk);
      #3;
      chk("pmem_rw_exclusive", 32'(bus.pmem_read & bus.pmem_write), 32'(0));
      chk("resp_without_req", 32'(bus.mem_resp & ~(bus.mem_read | bus.mem_write)), 32'(0));
      chk("pmem_wdata_idle", 32'(!bus.pmem_write && (bus.pmem_wdata != '0)), 32'(0));
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // CPU scoreboard
  typedef struct {
    logic [15:0] rd;
    int          wt;
  } exp_t;
  exp_t sb_q[$];

  task automatic cpu_op(input logic rd, input logic wr, input logic [15:0] a,
                        input logic [1:0] be, input logic [15:0] wd,
                        input logic [15:0] exp_rd, input int exp_wait, input string name);
    exp_t e;
    int   waited;
    bit   done;
    sb_q.push_back('{exp_rd, exp_wait});
    @(negedge clk);
    bus.mem_read        = rd;
    bus.mem_write       = wr;
    bus.mem_address     = a;
    bus.mem_byte_enable = be;
    bus.mem_wdata       = wd;
    waited = 0;
    done   = 1'b0;
    while (!done && waited < 40) begin
      #1;
      if (bus.mem_resp === 1'b1) begin
        e = sb_q.pop_front();
        chk({name, "_rdata"}, 32'(bus.mem_rdata), 32'(e.rd));
        chk({name, "_latency"}, waited, e.wt);
        done = 1'b1;
      end else begin
        @(negedge clk);
        waited++;
      end
    end
    if (!done) begin
      e = sb_q.pop_front();
      checks++;
      failures++;
      $display("FAIL %s_timeout: no mem_resp after %0d cycles, expected after %0d", name, waited, e.wt);
    end
    @(posedge clk);
    #1;
    bus.mem_read  = 1'b0;
    bus.mem_write = 1'b0;
  endtask

  typedef struct {
    logic        rd;
    logic        wr;
    logic [15:0] addr;
    logic [1:0]  be;
    logic [15:0] wd;
    logic [15:0] exp_rd;
    int          kind;     // 0 hit, 1 clean miss, 2 dirty miss
    logic [15:0] wb_addr;
  } vec_t;
  vec_t vecs[NV];

  function automatic int kind_wait(input int kind);
    if (kind == 0) return 0;
    if (kind == 1) return LAT + 1;
    return 2*LAT + 1;
  endfunction

  initial begin
    logic [127:0] l0;
    int  nwb, nfill, k;
    bit  saw;

    vecs[0]  = '{1'b1, 1'b0, 16'h0124, 2'b00, 16'h0000, 16'hBEEF, 1, 16'h0000};
    vecs[1]  = '{1'b0, 1'b1, 16'h0124, 2'b01, 16'h12AB, 16'h0000, 0, 16'h0000};
    vecs[2]  = '{1'b1, 1'b0, 16'h0124, 2'b00, 16'h0000, 16'hBEAB, 0, 16'h0000};
    vecs[3]  = '{1'b1, 1'b0, 16'h0125, 2'b00, 16'h0000, 16'hBEAB, 0, 16'h0000};
    vecs[4]  = '{1'b0, 1'b1, 16'h0126, 2'b00, 16'hFFFF, 16'h0000, 0, 16'h0000};
    vecs[5]  = '{1'b1, 1'b0, 16'h0126, 2'b00, 16'h0000, 16'hBEEF, 0, 16'h0000};
    vecs[6]  = '{1'b1, 1'b0, 16'h01A4, 2'b00, 16'h0000, 16'h01A4, 2, 16'h0120};
    vecs[7]  = '{1'b1, 1'b0, 16'h0124, 2'b00, 16'h0000, 16'hBEAB, 1, 16'h0000};
    vecs[8]  = '{1'b0, 1'b1, 16'h0310, 2'b11, 16'h5A5A, 16'h0000, 1, 16'h0000};
    vecs[9]  = '{1'b1, 1'b0, 16'h0310, 2'b00, 16'h0000, 16'h5A5A, 0, 16'h0000};
    vecs[10] = '{1'b0, 1'b1, 16'h0312, 2'b10, 16'h77CC, 16'h0000, 0, 16'h0000};
    vecs[11] = '{1'b1, 1'b0, 16'h0312, 2'b00, 16'h0000, 16'h7712, 0, 16'h0000};
    vecs[12] = '{1'b1, 1'b0, 16'h0390, 2'b00, 16'h0000, 16'h0390, 2, 16'h0310};
    vecs[13] = '{1'b1, 1'b0, 16'h0312, 2'b00, 16'h0000, 16'h7712, 1, 16'h0000};
    vecs[14] = '{1'b1, 1'b1, 16'h0314, 2'b11, 16'h4321, 16'h0000, 0, 16'h0000};
    vecs[15] = '{1'b1, 1'b0, 16'h0314, 2'b00, 16'h0000, 16'h4321, 0, 16'h0000};

    l0 = pattern(16'h0120);
    l0[47:32] = 16'hBEEF;
    l0[63:48] = 16'hBEEF;
    mem[16'h0120] = l0;

    // Reset state, with a request already presented
    reset               = 1'b0;
    bus.mem_read        = 1'b1;
    bus.mem_write       = 1'b0;
    bus.mem_address     = 16'h0124;
    bus.mem_byte_enable = 2'b00;
    bus.mem_wdata       = '0;
    #12;
    chk("rst_mem_resp", 32'(bus.mem_resp), 32'(0));
    chk("rst_pmem_read", 32'(bus.pmem_read), 32'(0));
    chk("rst_pmem_write", 32'(bus.pmem_write), 32'(0));
    chk("rst_pmem_address", 32'(bus.pmem_address), 32'(0));
    chk("rst_mem_rdata", 32'(bus.mem_rdata), 32'(0));
    bus.mem_read = 1'b0;
    @(negedge clk);
    reset = 1'b1;

    for (int i = 0; i < NV; i++) begin
      nwb   = wb_addr_q.size();
      nfill = fill_addr_q.size();
      cpu_op(vecs[i].rd, vecs[i].wr, vecs[i].addr, vecs[i].be, vecs[i].wd,
             vecs[i].exp_rd, kind_wait(vecs[i].kind), $sformatf("v%0d", i));
      chk($sformatf("v%0d_wb_count", i), wb_addr_q.size() - nwb, (vecs[i].kind == 2) ? 1 : 0);
      if (vecs[i].kind == 2 && wb_addr_q.size() > nwb)
        chk($sformatf("v%0d_wb_addr", i), 32'(wb_addr_q[$]), 32'(vecs[i].wb_addr));
      chk($sformatf("v%0d_fill_count", i), fill_addr_q.size() - nfill, (vecs[i].kind != 0) ? 1 : 0);
      if (vecs[i].kind != 0 && fill_addr_q.size() > nfill)
        chk($sformatf("v%0d_fill_addr", i), 32'(fill_addr_q[$]), 32'(vecs[i].addr & 16'hFFF0));
    end

    // Victim line contents seen by memory
    if (wb_data_q.size() >= 2) begin
      l0 = wb_data_q[0];
      chk("wb0_word2", 32'(l0[47:32]), 32'(16'hBEAB));
      chk("wb0_word3", 32'(l0[63:48]), 32'(16'hBEEF));
      l0 = wb_data_q[1];
      chk("wb1_word0", 32'(l0[15:0]), 32'(16'h5A5A));
      chk("wb1_word1", 32'(l0[31:16]), 32'(16'h7712));
    end else begin
      checks++;
      failures++;
      $display("FAIL wb_log: got %0d writebacks expected 2", wb_data_q.size());
    end

    // Abandoned miss: request dropped during FILL
    @(negedge clk);
    bus.mem_read    = 1'b1;
    bus.mem_address = 16'h0300;
    #1;
    for (k = 0; k < 20 && bus.pmem_read !== 1'b1; k++) begin
      @(negedge clk);
      #1;
    end
    chk("abandon_fill_seen", 32'(bus.pmem_read), 32'(1));
    chk("abandon_fill_addr", 32'(bus.pmem_address), 32'(16'h0300));
    bus.mem_read = 1'b0;
    saw = 1'b0;
    repeat (8) begin
      @(negedge clk);
      #1;
      if (bus.mem_resp === 1'b1) saw = 1'b1;
    end
    chk("abandon_no_resp", 32'(saw), 32'(0));
    chk("abandon_idle", 32'(bus.pmem_read), 32'(0));
    cpu_op(1'b1, 1'b0, 16'h0300, 2'b00, 16'h0, 16'h0300, 0, "abandon_rehit");

    // Zero byte-enable write hit leaves the line clean
    cpu_op(1'b0, 1'b1, 16'h0302, 2'b00, 16'hFFFF, 16'h0000, 0, "be00_write");
    cpu_op(1'b1, 1'b0, 16'h0302, 2'b00, 16'h0, 16'h0302, 0, "be00_read");
    nwb = wb_addr_q.size();
    cpu_op(1'b1, 1'b0, 16'h0380, 2'b00, 16'h0, 16'h0380, LAT + 1, "be00_evict");
    chk("be00_no_wb", wb_addr_q.size() - nwb, 0);

    // Reset in the middle of FILL, then a stray late pmem_resp
    cpu_op(1'b1, 1'b0, 16'h0124, 2'b00, 16'h0, 16'hBEAB, 0, "pre_abort_hit");
    @(negedge clk);
    bus.mem_read    = 1'b1;
    bus.mem_address = 16'h01A4;
    #1;
    for (k = 0; k < 20 && bus.pmem_read !== 1'b1; k++) begin
      @(negedge clk);
      #1;
    end
    chk("abort_fill_seen", 32'(bus.pmem_read), 32'(1));
    #1;
    reset = 1'b0;
    #1;
    chk("abort_pmem_read", 32'(bus.pmem_read), 32'(0));
    chk("abort_pmem_address", 32'(bus.pmem_address), 32'(0));
    bus.mem_read = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    mem_hold = 1'b1;
    @(negedge clk);
    bus.pmem_rdata = '1;
    bus.pmem_resp  = 1'b1;
    @(negedge clk);
    bus.pmem_resp = 1'b0;
    mem_hold      = 1'b0;
    #1;
    chk("late_resp_pmem_read", 32'(bus.pmem_read), 32'(0));
    chk("late_resp_pmem_write", 32'(bus.pmem_write), 32'(0));
    nfill = fill_addr_q.size();
    cpu_op(1'b1, 1'b0, 16'h0124, 2'b00, 16'h0, 16'hBEAB, LAT + 1, "post_reset_miss");
    chk("post_reset_fill_count", fill_addr_q.size() - nfill, 1);

    repeat (2) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
